memory_handshake_ram: RTL

- Byte-addressed, big-endian data/instruction memory.
- Sits directly downstream of the control unit's datapath: consumes MOV, R_W, the access size, MAR address and MDR write data.
- Returns read data to MDR and asserts MOC to complete the memory wait states of the microprogram.
- Adds a programmable wait-state counter and a byte preload port for loading test programs.

---
 rtl/memory_handshake_ram.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/memory_handshake_ram.sv
// Byte-addressed big-endian RAM with a MOV/MOC handshake, a programmable
// wait-state counter and a byte preload port for loading test images.
module memory_handshake_ram #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MOV,
  input  logic              R_W,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic [31:0]       data_out,
  output logic              MOC,
  output logic              align_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              rw_q, rw_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              moc_q, moc_d;
  logic              aerr_q, aerr_d;
  logic [31:0]       dout_q, dout_d;
  logic [7:0]        mem_q [DEPTH];

  logic [ADDR_W-1:0] a1_s, a2_s, a3_s;
  logic              mis_s;
  logic              access_s;
  logic [31:0]       rdata_s;

  // Halfword needs an even address, word (and reserved) a 4-byte boundary.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a_lo);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a_lo[0];
      default: return (a_lo != 2'b00);
    endcase
  endfunction

  assign a1_s     = addr_q + ADDR_W'(1);
  assign a2_s     = addr_q + ADDR_W'(2);
  assign a3_s     = addr_q + ADDR_W'(3);
  assign mis_s    = misaligned(size_q, addr_q[1:0]);
  assign access_s = (state_q == BUSY) && MOV && (cnt_q == 4'd0);

  // Big-endian read assembly from the latched address, zero-extended.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (size_q)
      2'b00:   rdata_s = {24'h00_0000, mem_q[addr_q]};
      2'b01:   rdata_s = {16'h0000, mem_q[addr_q], mem_q[a1_s]};
      default: rdata_s = {mem_q[addr_q], mem_q[a1_s], mem_q[a2_s], mem_q[a3_s]};
    endcase
  end

  // Next-state and registered-output logic of the handshake FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    moc_d   = moc_q;
    aerr_d  = aerr_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        moc_d  = 1'b0;
        aerr_d = 1'b0;
        if (ld_en) begin
          state_d = IDLE;
        end else if (MOV) begin
          addr_d  = address;
          size_d  = size;
          rw_d    = R_W;
          wdata_d = data_in;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!MOV) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          moc_d   = 1'b1;
          aerr_d  = mis_s;
          if (rw_q) begin
            dout_d = mis_s ? 32'h0000_0000 : rdata_s;
          end else begin
            dout_d = dout_q;
          end
        end
      end
      DONE: begin
        if (!MOV) begin
          state_d = IDLE;
          moc_d   = 1'b0;
          aerr_d  = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        moc_d   = 1'b0;
        aerr_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers; memory contents survive reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      rw_q    <= 1'b0;
      wdata_q <= 32'h0000_0000;
      moc_q   <= 1'b0;
      aerr_q  <= 1'b0;
      dout_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      moc_q   <= moc_d;
      aerr_q  <= aerr_d;
      dout_q  <= dout_d;
    end
  end

  // Array writes: preload in IDLE, or an aligned write on the BUSY->DONE edge.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && ld_en) begin
      mem_q[ld_addr] <= ld_data;
    end else if (access_s && !rw_q && !mis_s) begin
      case (size_q)
        2'b00: mem_q[addr_q] <= wdata_q[7:0];
        2'b01: begin
          mem_q[addr_q] <= wdata_q[15:8];
          mem_q[a1_s]   <= wdata_q[7:0];
        end
        default: begin
          mem_q[addr_q] <= wdata_q[31:24];
          mem_q[a1_s]   <= wdata_q[23:16];
          mem_q[a2_s]   <= wdata_q[15:8];
          mem_q[a3_s]   <= wdata_q[7:0];
        end
      endcase
    end
  end

  assign data_out  = dout_q;
  assign MOC       = moc_q;
  assign align_err = aerr_q;

endmodule
